// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, op-code width, FSM states.
// No logic; constants and types only.
// Imported by the shared ALU and by the arbiter top.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SUM  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_SRCB = 3'd4;
    localparam logic [OP_W-1:0] OP_SLT  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Shared 32-bit ALU datapath: sum, sub, and, or, pass-B, signed set-less-than.
// Purely combinational, zero cycles of latency.
// No flow control; the owner of the operand registers decides when to sample it.
module alu_share_arbiter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    output logic [WIDTH-1:0] y_o,
    output logic             zero_o,
    output logic             err_o
);

    // Result select; illegal codes produce a defined zero result with err set.
    always_comb begin
        y_o   = '0;
        err_o = 1'b0;
        case (op_i)
            OP_SUM:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_SRCB: y_o = b_i;
            OP_SLT:  y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: err_o = 1'b1;
        endcase
    end

    assign zero_o = ~|y_o;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters (ALU_ARB_STATS_EN adds grant counters).
// Latency: accept -> EXEC -> response registered, rsp valid two edges after the ready cycle; one op in flight.
// Backpressure: requests wait (ready low) outside IDLE; a result is held stable until its rsp_ready.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_zero,
    output logic             rsp0_err,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_zero,
    output logic             rsp1_err
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] gnt0_cnt,
    output logic [CNT_W-1:0] gnt1_cnt
`endif
);

    state_t           state_q;
    logic             prio_q;      // port favoured when both request at once
    logic             owner_q;     // port whose operation is in flight
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OP_W-1:0]  op_q;

    logic [1:0]       rsp_vld_q;
    logic [1:0]       rsp_zero_q;
    logic [1:0]       rsp_err_q;
    logic [WIDTH-1:0] rsp_dat_q [2];

    logic             gnt;         // 0 selects port 0, 1 selects port 1
    logic             acc;
    logic             rsp_hs;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [OP_W-1:0]  sel_op;

    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;
    logic             alu_err;

    // Grant, ready and payload select; ready is held low during reset so no
    // requester believes an operation was taken that the FSM will ignore.
    always_comb begin
        gnt        = (req0_valid && req1_valid) ? prio_q : req1_valid;
        req0_ready = (state_q == IDLE) && !rst && req0_valid && !gnt;
        req1_ready = (state_q == IDLE) && !rst && req1_valid &&  gnt;
        acc        = req0_ready || req1_ready;
        sel_a      = gnt ? req1_a  : req0_a;
        sel_b      = gnt ? req1_b  : req0_b;
        sel_op     = gnt ? req1_op : req0_op;
        rsp_hs     = owner_q ? (rsp_vld_q[1] && rsp1_ready)
                             : (rsp_vld_q[0] && rsp0_ready);
    end

    alu_share_arbiter_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_i    (a_q),
        .b_i    (b_q),
        .op_i   (op_q),
        .y_o    (alu_y),
        .zero_o (alu_zero),
        .err_o  (alu_err)
    );

    // Issue FSM: latch the granted operation, capture the ALU result into the
    // owner's response registers, then hold it until the owner consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_vld_q    <= '0;
            rsp_zero_q   <= '0;
            rsp_err_q    <= '0;
            rsp_dat_q[0] <= '0;
            rsp_dat_q[1] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        op_q    <= sel_op;
                        owner_q <= gnt;
                        prio_q  <= ~gnt;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_dat_q[owner_q]  <= alu_y;
                    rsp_zero_q[owner_q] <= alu_zero;
                    rsp_err_q[owner_q]  <= alu_err;
                    rsp_vld_q[owner_q]  <= 1'b1;
                    state_q             <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp_vld_q[owner_q] <= 1'b0;
                        state_q            <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = rsp_vld_q[0];
    assign rsp0_data  = rsp_dat_q[0];
    assign rsp0_zero  = rsp_zero_q[0];
    assign rsp0_err   = rsp_err_q[0];
    assign rsp1_valid = rsp_vld_q[1];
    assign rsp1_data  = rsp_dat_q[1];
    assign rsp1_zero  = rsp_zero_q[1];
    assign rsp1_err   = rsp_err_q[1];

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] gnt0_cnt_q;
    logic [CNT_W-1:0] gnt1_cnt_q;

    // Saturating per-port grant counters; a clear wins over a same-cycle grant.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            gnt0_cnt_q <= '0;
            gnt1_cnt_q <= '0;
        end else begin
            if (req0_valid && req0_ready && (gnt0_cnt_q != '1)) begin
                gnt0_cnt_q <= gnt0_cnt_q + 1'b1;
            end
            if (req1_valid && req1_ready && (gnt1_cnt_q != '1)) begin
                gnt1_cnt_q <= gnt1_cnt_q + 1'b1;
            end
        end
    end

    assign gnt0_cnt = gnt0_cnt_q;
    assign gnt1_cnt = gnt1_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table, corner sequences, random vs. model.
// Inputs change 1 time unit after the rising edge; outputs are compared 2 units after it.
// Stats checks are compiled only when ALU_ARB_STATS_EN is defined.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic [31:0] req0_a, req0_b, rsp0_data;
    logic [2:0]  req0_op;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [31:0] req1_a, req1_b, rsp1_data;
    logic [2:0]  req1_op;
`ifdef ALU_ARB_STATS_EN
    logic        clr_stats;
    logic [15:0] gnt0_cnt, gnt1_cnt;
`endif

    int checks = 0;
    int errors = 0;

    alu_share_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_zero  (rsp0_zero),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_zero  (rsp1_zero),
        .rsp1_err   (rsp1_err)
`ifdef ALU_ARB_STATS_EN
        ,
        .clr_stats  (clr_stats),
        .gnt0_cnt   (gnt0_cnt),
        .gnt1_cnt   (gnt1_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        z;
        logic        e;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference ALU from the op-code definitions.
    task automatic ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] d, output logic z, output logic e);
        e = 1'b0;
        case (op)
            3'd0: d = a + b;
            3'd1: d = a - b;
            3'd2: d = a & b;
            3'd3: d = a | b;
            3'd4: d = b;
            3'd5: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin d = 32'd0; e = 1'b1; end
        endcase
        z = (d == 32'd0);
    endtask

    logic        got;
    int          n;
    logic [31:0] held;
    int          gq[$];

    // Random-test model state
    int          ph;          // 0 idle, 1 executing, 2 responding
    bit          own, fav, hs_acc, hs_port, hs_rsp, er0, er1;
    bit          p_v [2];
    logic [31:0] p_a [2];
    logic [31:0] p_b [2];
    logic [2:0]  p_op [2];
    logic [31:0] m_d;
    logic        m_z, m_e;

    initial begin
        vecs[0]  = '{3'd1, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[1]  = '{3'd0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0};
        vecs[2]  = '{3'd0, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, 1'b0};
        vecs[3]  = '{3'd2, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0};
        vecs[4]  = '{3'd3, 32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 1'b0, 1'b0};
        vecs[5]  = '{3'd4, 32'd9,        32'd0,        32'h00000000, 1'b1, 1'b0};
        vecs[6]  = '{3'd4, 32'd0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[7]  = '{3'd5, 32'hFFFFFFFD, 32'd2,        32'h00000001, 1'b0, 1'b0};
        vecs[8]  = '{3'd5, 32'd2,        32'hFFFFFFFD, 32'h00000000, 1'b1, 1'b0};
        vecs[9]  = '{3'd5, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0};
        vecs[10] = '{3'd1, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[11] = '{3'd6, 32'd3,        32'd4,        32'h00000000, 1'b1, 1'b1};
        vecs[12] = '{3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1};

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
`ifdef ALU_ARB_STATS_EN
        clr_stats = 1'b0;
`endif
        do_reset();

        // Reset state
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_data", rsp0_data, 0);
        chk("rst_rsp1_data", rsp1_data, 0);
        chk("rst_rsp0_zero", rsp0_zero, 0);
        chk("rst_rsp1_zero", rsp1_zero, 0);
        chk("rst_rsp0_err", rsp0_err, 0);
        chk("rst_rsp1_err", rsp1_err, 0);
        chk("rst_req0_ready_idle", req0_ready, 0);

        // Latency: SUB 5-7 on port 0
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        chk("lat_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("lat_exec_rsp0_valid", rsp0_valid, 0);
        chk("lat_exec_req0_ready", req0_ready, 0);
        tick();
        chk("lat_rsp0_valid", rsp0_valid, 1);
        chk("lat_rsp0_data", rsp0_data, 32'hFFFFFFFE);
        chk("lat_rsp0_zero", rsp0_zero, 0);
        chk("lat_rsp0_err", rsp0_err, 0);
        tick();
        chk("lat_rsp0_consumed", rsp0_valid, 0);

        // Vector table on port 0
        for (int i = 0; i < 13; i++) begin
            req0_valid = 1'b1; req0_op = vecs[i].op; req0_a = vecs[i].a; req0_b = vecs[i].b;
            #1;
            got = 1'b0;
            for (int w = 0; w < 8; w++) begin
                if (req0_ready) begin got = 1'b1; break; end
                tick();
            end
            chk($sformatf("tbl%0d_accept", i), got, 1);
            tick();
            req0_valid = 1'b0;
            got = 1'b0;
            for (int w = 0; w < 8; w++) begin
                if (rsp0_valid) begin got = 1'b1; break; end
                tick();
            end
            chk($sformatf("tbl%0d_rsp", i), got, 1);
            chk($sformatf("tbl%0d_data", i), rsp0_data, vecs[i].d);
            chk($sformatf("tbl%0d_zero", i), rsp0_zero, vecs[i].z);
            chk($sformatf("tbl%0d_err", i), rsp0_err, vecs[i].e);
            tick();
        end

        // Both valid from reset: grants alternate starting with port 0
        do_reset();
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'h0000F0F0; req0_b = 32'h00000FF0;
        req1_valid = 1'b1; req1_op = 3'd5; req1_a = 32'hFFFFFFFD; req1_b = 32'd2;
        gq.delete();
        got = 1'b0;
        n = 0;
        for (int c = 0; c < 13; c++) begin
            #1;
            if (req0_ready) gq.push_back(0);
            if (req1_ready) gq.push_back(1);
            if (rsp0_valid && !got) begin
                got = 1'b1;
                chk("alt_rsp0_and", rsp0_data, 32'h000000F0);
            end
            if (rsp1_valid && n == 0) begin
                n = 1;
                chk("alt_rsp1_slt", rsp1_data, 32'd1);
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("alt_grant_count_ge4", (gq.size() >= 4) ? 1 : 0, 1);
        if (gq.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk($sformatf("alt_grant%0d", k), gq[k], k % 2);
        end
        tick(); tick(); tick();

        // Response backpressure on port 1 blocks port 0
        do_reset();
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'h7FFFFFFF; req1_b = 32'd1;
        #1;
        chk("bp_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd1; req0_b = 32'd1;
        tick();
        held = rsp1_data;
        chk("bp_rsp1_data", held, 32'h80000000);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_valid_c%0d", c), rsp1_valid, 1);
            chk($sformatf("bp_stable_c%0d", c), rsp1_data, 32'h80000000);
            chk($sformatf("bp_req0_blocked_c%0d", c), req0_ready, 0);
            tick();
        end
        rsp1_ready = 1'b1;
        #1;
        chk("bp_req0_blocked_hs", req0_ready, 0);
        tick();
        chk("bp_rsp1_done", rsp1_valid, 0);
        chk("bp_req0_accept", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick(); tick(); tick();

        // Reset during EXEC drops the op and restores port-0 priority
        do_reset();
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd1; req0_b = 32'd2;
        #1;
        chk("mid_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rsp0_valid", rsp0_valid, 0);
        chk("mid_rsp1_valid", rsp1_valid, 0);
        chk("mid_rsp0_data", rsp0_data, 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("mid_no_stale_c%0d", c), {rsp0_valid, rsp1_valid}, 0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mid_prio_ready0", req0_ready, 1);
        chk("mid_prio_ready1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

`ifdef ALU_ARB_STATS_EN
        // Grant counters: 3 on port 0, 2 on port 1, then clear beats a grant
        do_reset();
        chk("st_rst_cnt0", {16'd0, gnt0_cnt}, 0);
        req0_valid = 1'b1; req0_op = 3'd0;
        req1_valid = 1'b1; req1_op = 3'd0;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req0_ready || req1_ready) n++;
            if (n == 5) begin
                tick();
                req0_valid = 1'b0; req1_valid = 1'b0;
                break;
            end
            tick();
        end
        chk("st_grants_seen", n, 5);
        tick(); tick(); tick();
        chk("st_cnt0", {16'd0, gnt0_cnt}, 3);
        chk("st_cnt1", {16'd0, gnt1_cnt}, 2);
        req0_valid = 1'b1; clr_stats = 1'b1;
        #1;
        chk("st_clr_grant_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0; clr_stats = 1'b0;
        chk("st_clr_cnt0", {16'd0, gnt0_cnt}, 0);
        chk("st_clr_cnt1", {16'd0, gnt1_cnt}, 0);
        tick(); tick(); tick();
`endif

        // Randomized traffic against the transaction-level model
        do_reset();
        ph = 0; own = 0; fav = 0; hs_acc = 0; hs_port = 0; hs_rsp = 0;
        p_v[0] = 0; p_v[1] = 0;
        m_d = '0; m_z = 0; m_e = 0;
        for (int c = 0; c < 600; c++) begin
            if (c != 0) tick();
            case (ph)
                0: if (hs_acc) begin
                    ph = 1; own = hs_port; fav = !hs_port;
                    ref_alu(p_op[hs_port], p_a[hs_port], p_b[hs_port], m_d, m_z, m_e);
                    p_v[hs_port] = 0;
                end
                1: ph = 2;
                default: if (hs_rsp) ph = 0;
            endcase
            for (int p = 0; p < 2; p++) begin
                if (!p_v[p] && $urandom_range(0, 2) == 0) begin
                    p_v[p]  = 1;
                    p_op[p] = 3'($urandom_range(0, 7));
                    p_a[p]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
                    p_b[p]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
                end
            end
            req0_valid = p_v[0]; req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
            req1_valid = p_v[1]; req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            #1;
            er0 = (ph == 0) && p_v[0] && (!p_v[1] || !fav);
            er1 = (ph == 0) && p_v[1] && (!p_v[0] || fav);
            chk("rnd_req0_ready", req0_ready, er0);
            chk("rnd_req1_ready", req1_ready, er1);
            chk("rnd_rsp0_valid", rsp0_valid, (ph == 2) && !own);
            chk("rnd_rsp1_valid", rsp1_valid, (ph == 2) && own);
            if (ph == 2) begin
                chk("rnd_data", own ? rsp1_data : rsp0_data, m_d);
                chk("rnd_zero", own ? rsp1_zero : rsp0_zero, m_z);
                chk("rnd_err",  own ? rsp1_err  : rsp0_err,  m_e);
            end
            hs_acc  = er0 || er1;
            hs_port = er1;
            hs_rsp  = (ph == 2) && (own ? rsp1_ready : rsp0_ready);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
